// File: rtl/ahb_bus_arbiter.sv
// AHB master-port arbiter for the MMU walker and the I/D cache bus units.
// One registered owner at a time, an idle handover cycle, and a hung-transfer watchdog.
module ahb_bus_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int BUS_WIDTH = 8,
    parameter int BUS_ADDR  = 24,
    parameter int RR_EN     = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            bus_req,
    output logic [NUM_REQ-1:0]            bus_ack,
    input  logic [NUM_REQ*BUS_ADDR-1:0]   m_haddr,
    input  logic [NUM_REQ-1:0]            m_hwrite,
    input  logic [NUM_REQ*3-1:0]          m_hburst,
    input  logic [NUM_REQ*2-1:0]          m_htrans,
    input  logic [NUM_REQ*BUS_WIDTH-1:0]  m_hwdata,
    output logic [NUM_REQ-1:0]            m_hready,
    output logic [NUM_REQ-1:0]            m_hresp,
    output logic [BUS_WIDTH-1:0]          m_hrdata,
    output logic [BUS_ADDR-1:0]           haddr,
    output logic                          hwrite,
    output logic [2:0]                    hburst,
    output logic [1:0]                    htrans,
    output logic [BUS_WIDTH-1:0]          hwdata,
    input  logic                          hready,
    input  logic                          hresp,
    input  logic [BUS_WIDTH-1:0]          hrdata,
    output logic                          bus_timeout
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ARB = 2'd0,
        OWN = 2'd1,
        REL = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [NUM_REQ-1:0]   r_ack;
    logic [NUM_REQ-1:0]   w_ack_nxt;
    logic [IW-1:0]        r_owner;
    logic [IW-1:0]        w_owner_nxt;
    logic [IW-1:0]        r_last;
    logic [IW-1:0]        w_last_nxt;
    logic [NUM_REQ-1:0]   r_mask;
    logic [NUM_REQ-1:0]   w_mask_set;
    logic                 r_timeout;
    logic                 w_timeout_nxt;
    logic [IW-1:0]        r_downer;
    logic                 r_dvalid;
    logic [CW-1:0]        r_wdog;
    logic                 w_fire;
    logic [NUM_REQ-1:0]   w_elig;
    logic                 w_found;
    logic [IW-1:0]        w_win;
    int                   w_idx;
    logic [NUM_REQ-1:0]   w_route;

    assign w_elig      = bus_req & ~r_mask;
    assign w_fire      = (r_state == OWN) && !hready && (r_wdog == CW'(TIMEOUT));
    assign bus_ack     = r_ack;
    assign bus_timeout = r_timeout;
    assign m_hrdata    = hrdata;

    // Round-robin starts one past the last winner; fixed priority starts at 0.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (RR_EN != 0) begin
                w_idx = (int'(r_last) + k) % NUM_REQ;
            end else begin
                w_idx = k - 1;
            end
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_win   = IW'(w_idx);
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ack_nxt     = r_ack;
        w_owner_nxt   = r_owner;
        w_last_nxt    = r_last;
        w_mask_set    = '0;
        w_timeout_nxt = 1'b0;
        case (r_state)
            ARB: begin
                if (w_found) begin
                    w_ack_nxt        = '0;
                    w_ack_nxt[w_win] = 1'b1;
                    w_owner_nxt      = w_win;
                    w_last_nxt       = w_win;
                    w_state_nxt      = OWN;
                end
            end
            OWN: begin
                if (w_fire) begin
                    w_ack_nxt           = '0;
                    w_mask_set[r_owner] = 1'b1;
                    w_timeout_nxt       = 1'b1;
                    w_state_nxt         = REL;
                end else if (!bus_req[r_owner]) begin
                    w_ack_nxt   = '0;
                    w_state_nxt = REL;
                end
            end
            REL: begin
                w_ack_nxt   = '0;
                w_state_nxt = ARB;
            end
            default: begin
                w_ack_nxt   = '0;
                w_state_nxt = ARB;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ARB;
            r_ack     <= '0;
            r_owner   <= '0;
            r_last    <= IW'(NUM_REQ - 1);
            r_mask    <= '0;
            r_timeout <= 1'b0;
            r_downer  <= '0;
            r_dvalid  <= 1'b0;
            r_wdog    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ack     <= w_ack_nxt;
            r_owner   <= w_owner_nxt;
            r_last    <= w_last_nxt;
            r_timeout <= w_timeout_nxt;
            r_mask    <= (r_mask | w_mask_set) & bus_req;
            if (hready) begin
                r_downer <= r_owner;
                r_dvalid <= (r_state == OWN);
            end
            if ((r_state == OWN) && !hready && !w_fire) begin
                r_wdog <= r_wdog + CW'(1);
            end else begin
                r_wdog <= '0;
            end
        end
    end

    // Address phase follows the owner; data phase follows whoever owned the last accepted address.
    always_comb begin
        haddr  = '0;
        hwrite = 1'b0;
        hburst = 3'b000;
        htrans = 2'b00;
        hwdata = '0;
        if (r_state == OWN) begin
            haddr  = m_haddr[int'(r_owner)*BUS_ADDR +: BUS_ADDR];
            hwrite = m_hwrite[r_owner];
            hburst = m_hburst[int'(r_owner)*3 +: 3];
            htrans = m_htrans[int'(r_owner)*2 +: 2];
        end
        if (r_dvalid) begin
            hwdata = m_hwdata[int'(r_downer)*BUS_WIDTH +: BUS_WIDTH];
        end
    end

    always_comb begin
        w_route  = '0;
        m_hready = '0;
        m_hresp  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_route[i]  = ((r_state == OWN) && (int'(r_owner) == i)) ||
                          (r_dvalid && (int'(r_downer) == i));
            m_hready[i] = hready & w_route[i];
            m_hresp[i]  = hresp & w_route[i];
        end
    end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter: vector table plus multi-cycle sequences.
// A second fixed-priority instance shares the stimulus.
module tb_ahb_bus_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  bus_req;
    logic [2:0]  bus_ack;
    logic [71:0] m_haddr;
    logic [2:0]  m_hwrite;
    logic [8:0]  m_hburst;
    logic [5:0]  m_htrans;
    logic [23:0] m_hwdata;
    logic [2:0]  m_hready;
    logic [2:0]  m_hresp;
    logic [7:0]  m_hrdata;
    logic [23:0] haddr;
    logic        hwrite;
    logic [2:0]  hburst;
    logic [1:0]  htrans;
    logic [7:0]  hwdata;
    logic        hready;
    logic        hresp;
    logic [7:0]  hrdata;
    logic        bus_timeout;

    logic [2:0]  fp_ack;
    logic [2:0]  fp_hready;
    logic [2:0]  fp_hresp;
    logic [7:0]  fp_hrdata;
    logic [23:0] fp_haddr;
    logic        fp_hwrite;
    logic [2:0]  fp_hburst;
    logic [1:0]  fp_htrans;
    logic [7:0]  fp_hwdata;
    logic        fp_timeout;

    int n_pass;
    int n_chk;
    int cyc;

    typedef struct {
        logic [2:0]  req;
        logic        hrdy;
        logic        hrsp;
        logic [2:0]  ack;
        logic [1:0]  trans;
        logic [23:0] addr;
        logic [2:0]  burst;
        logic        wr;
        logic [7:0]  wdata;
        logic [2:0]  mrdy;
        logic [2:0]  mrsp;
    } vec_t;

    vec_t tbl[17];
    int   order[4];

    ahb_bus_arbiter #(
        .NUM_REQ(3), .BUS_WIDTH(8), .BUS_ADDR(24), .RR_EN(1), .TIMEOUT(4)
    ) dut (
        .clk(clk), .rst(rst), .bus_req(bus_req), .bus_ack(bus_ack),
        .m_haddr(m_haddr), .m_hwrite(m_hwrite), .m_hburst(m_hburst),
        .m_htrans(m_htrans), .m_hwdata(m_hwdata), .m_hready(m_hready),
        .m_hresp(m_hresp), .m_hrdata(m_hrdata), .haddr(haddr),
        .hwrite(hwrite), .hburst(hburst), .htrans(htrans), .hwdata(hwdata),
        .hready(hready), .hresp(hresp), .hrdata(hrdata),
        .bus_timeout(bus_timeout)
    );

    ahb_bus_arbiter #(
        .NUM_REQ(3), .BUS_WIDTH(8), .BUS_ADDR(24), .RR_EN(0), .TIMEOUT(4)
    ) dut_fp (
        .clk(clk), .rst(rst), .bus_req(bus_req), .bus_ack(fp_ack),
        .m_haddr(m_haddr), .m_hwrite(m_hwrite), .m_hburst(m_hburst),
        .m_htrans(m_htrans), .m_hwdata(m_hwdata), .m_hready(fp_hready),
        .m_hresp(fp_hresp), .m_hrdata(fp_hrdata), .haddr(fp_haddr),
        .hwrite(fp_hwrite), .hburst(fp_hburst), .htrans(fp_htrans),
        .hwdata(fp_hwdata), .hready(hready), .hresp(hresp),
        .hrdata(hrdata), .bus_timeout(fp_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bus_req = 3'b000;
        hready  = 1'b1;
        hresp   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_pass   = 0;
        n_chk    = 0;
        m_haddr  = {24'h222C22, 24'h111B11, 24'h000A00};
        m_hwrite = 3'b110;
        m_hburst = {3'b101, 3'b011, 3'b001};
        m_htrans = {2'b10, 2'b11, 2'b10};
        m_hwdata = {8'hC2, 8'hB1, 8'hA0};
        hrdata   = 8'h5A;

        // req hrdy hrsp | ack trans addr burst wr wdata mrdy mrsp
        tbl[0]  = '{3'b000,1,0, 3'b000,2'b00,24'h0,     3'b000,0,8'h00,3'b000,3'b000};
        tbl[1]  = '{3'b010,1,0, 3'b000,2'b00,24'h0,     3'b000,0,8'h00,3'b000,3'b000};
        tbl[2]  = '{3'b010,1,0, 3'b010,2'b11,24'h111B11,3'b011,1,8'h00,3'b010,3'b000};
        tbl[3]  = '{3'b010,1,0, 3'b010,2'b11,24'h111B11,3'b011,1,8'hB1,3'b010,3'b000};
        tbl[4]  = '{3'b000,1,0, 3'b010,2'b11,24'h111B11,3'b011,1,8'hB1,3'b010,3'b000};
        tbl[5]  = '{3'b000,1,0, 3'b000,2'b00,24'h0,     3'b000,0,8'hB1,3'b010,3'b000};
        tbl[6]  = '{3'b000,1,0, 3'b000,2'b00,24'h0,     3'b000,0,8'h00,3'b000,3'b000};
        tbl[7]  = '{3'b100,1,0, 3'b000,2'b00,24'h0,     3'b000,0,8'h00,3'b000,3'b000};
        tbl[8]  = '{3'b100,1,0, 3'b100,2'b10,24'h222C22,3'b101,1,8'h00,3'b100,3'b000};
        tbl[9]  = '{3'b101,1,0, 3'b100,2'b10,24'h222C22,3'b101,1,8'hC2,3'b100,3'b000};
        tbl[10] = '{3'b001,1,0, 3'b100,2'b10,24'h222C22,3'b101,1,8'hC2,3'b100,3'b000};
        tbl[11] = '{3'b001,1,0, 3'b000,2'b00,24'h0,     3'b000,0,8'hC2,3'b100,3'b000};
        tbl[12] = '{3'b001,1,0, 3'b000,2'b00,24'h0,     3'b000,0,8'h00,3'b000,3'b000};
        tbl[13] = '{3'b001,1,0, 3'b001,2'b10,24'h000A00,3'b001,0,8'h00,3'b001,3'b000};
        tbl[14] = '{3'b001,1,1, 3'b001,2'b10,24'h000A00,3'b001,0,8'hA0,3'b001,3'b001};
        tbl[15] = '{3'b000,1,0, 3'b001,2'b10,24'h000A00,3'b001,0,8'hA0,3'b001,3'b000};
        tbl[16] = '{3'b000,1,0, 3'b000,2'b00,24'h0,     3'b000,0,8'hA0,3'b001,3'b000};
        order   = '{0, 1, 2, 0};

        do_reset();
        chk("reset ack", 32'(bus_ack), 32'h0);
        chk("reset timeout", 32'(bus_timeout), 32'h0);
        chk("reset haddr", 32'(haddr), 32'h0);
        chk("reset ctrl", 32'({hwrite, hburst, htrans}), 32'h0);
        chk("reset hwdata", 32'(hwdata), 32'h0);
        chk("reset mready", 32'({m_hready, m_hresp}), 32'h0);
        chk("hrdata bcast", 32'(m_hrdata), 32'h5A);

        for (int i = 0; i < 17; i++) begin
            bus_req = tbl[i].req;
            hready  = tbl[i].hrdy;
            hresp   = tbl[i].hrsp;
            @(negedge clk);
            chk($sformatf("row%0d ack", i), 32'(bus_ack), 32'(tbl[i].ack));
            chk($sformatf("row%0d htrans", i), 32'(htrans), 32'(tbl[i].trans));
            chk($sformatf("row%0d haddr", i), 32'(haddr), 32'(tbl[i].addr));
            chk($sformatf("row%0d ctrl", i), 32'({hburst, hwrite}),
                32'({tbl[i].burst, tbl[i].wr}));
            chk($sformatf("row%0d hwdata", i), 32'(hwdata), 32'(tbl[i].wdata));
            chk($sformatf("row%0d mready", i), 32'(m_hready), 32'(tbl[i].mrdy));
            chk($sformatf("row%0d mresp", i), 32'(m_hresp), 32'(tbl[i].mrsp));
            @(posedge clk);
            #1;
        end

        // Round-robin with every requester cycling its request.
        do_reset();
        bus_req = 3'b111;
        for (int g = 0; g < 4; g++) begin
            cyc = 0;
            while (bus_ack == 3'b000 && cyc < 6) begin
                step();
                cyc++;
            end
            chk($sformatf("rr grant%0d", g), 32'(bus_ack), 32'(1 << order[g]));
            chk($sformatf("rr gap%0d", g), 32'(cyc), (g == 0) ? 32'd1 : 32'd2);
            for (int c = 0; c < 3; c++) begin
                step();
                chk($sformatf("rr hold%0d", g), 32'(bus_ack), 32'(1 << order[g]));
            end
            bus_req = bus_req & ~(3'(1 << order[g]));
            step();
            chk($sformatf("rr rel%0d", g), 32'({bus_ack, htrans}), 32'h0);
            bus_req = 3'b111;
        end

        // Fixed priority: lowest index first, then the still-pending one.
        do_reset();
        bus_req = 3'b101;
        step();
        chk("fp first", 32'(fp_ack), 32'h1);
        bus_req = 3'b100;
        step();
        chk("fp rel", 32'(fp_ack), 32'h0);
        step();
        chk("fp arb", 32'(fp_ack), 32'h0);
        step();
        chk("fp second", 32'(fp_ack), 32'h4);

        // Write data phase completes during REL while the slave stalls.
        do_reset();
        bus_req = 3'b010;
        step();
        chk("dp own", 32'({bus_ack, htrans}), 32'({3'b010, 2'b11}));
        bus_req = 3'b000;
        step();
        hready = 1'b0;
        #1;
        chk("dp rel htrans", 32'(htrans), 32'h0);
        chk("dp rel hwdata", 32'(hwdata), 32'hB1);
        chk("dp rel mready", 32'(m_hready), 32'h0);
        step();
        chk("dp stall hwdata", 32'(hwdata), 32'hB1);
        chk("dp stall mready", 32'(m_hready), 32'h0);
        hready = 1'b1;
        #1;
        chk("dp done mready", 32'(m_hready), 32'h2);
        chk("dp done hwdata", 32'(hwdata), 32'hB1);
        step();
        chk("dp after hwdata", 32'(hwdata), 32'h0);
        chk("dp after mready", 32'(m_hready), 32'h0);

        // Watchdog: owner 0 hangs, gets masked, requester 1 takes over.
        do_reset();
        bus_req = 3'b011;
        step();
        hready = 1'b0;
        chk("wd grant", 32'({bus_ack, bus_timeout}), 32'({3'b001, 1'b0}));
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("wd wait%0d", c), 32'({bus_ack, bus_timeout}),
                32'({3'b001, 1'b0}));
        end
        step();
        chk("wd fire", 32'({bus_ack, bus_timeout}), 32'({3'b000, 1'b1}));
        hready = 1'b1;
        step();
        chk("wd pulse end", 32'({bus_ack, bus_timeout}), 32'h0);
        step();
        chk("wd next owner", 32'(bus_ack), 32'h2);
        bus_req = 3'b001;
        step();
        step();
        step();
        chk("wd masked", 32'(bus_ack), 32'h0);
        bus_req = 3'b000;
        step();
        bus_req = 3'b001;
        step();
        chk("wd unmasked", 32'(bus_ack), 32'h1);

        // Asynchronous reset in the middle of an ownership.
        do_reset();
        bus_req = 3'b001;
        step();
        step();
        chk("ar own", 32'(bus_ack), 32'h1);
        #3;
        rst = 1'b1;
        #1;
        chk("ar ack", 32'(bus_ack), 32'h0);
        chk("ar idle", 32'({htrans, haddr}), 32'h0);
        #2;
        rst     = 1'b0;
        bus_req = 3'b111;
        step();
        chk("ar first", 32'(bus_ack), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
